// File: rtl/td4_core.sv
// TD4-compatible single-cycle accumulator CPU core.
// Executes one instruction from an asynchronous ROM per enabled clock edge.
module td4_core #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W+3:0] data,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic              carry
);

    localparam logic [3:0] OpAddA  = 4'b0000;
    localparam logic [3:0] OpMovAB = 4'b0001;
    localparam logic [3:0] OpInA   = 4'b0010;
    localparam logic [3:0] OpMovAI = 4'b0011;
    localparam logic [3:0] OpMovBA = 4'b0100;
    localparam logic [3:0] OpAddB  = 4'b0101;
    localparam logic [3:0] OpInB   = 4'b0110;
    localparam logic [3:0] OpMovBI = 4'b0111;
    localparam logic [3:0] OpOutB  = 4'b1001;
    localparam logic [3:0] OpOutI  = 4'b1011;
    localparam logic [3:0] OpJnc   = 4'b1110;
    localparam logic [3:0] OpJmp   = 4'b1111;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              c_q, c_d;

    logic [3:0]        opcode;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_sum;
    logic              alu_c;

    always_comb begin
        opcode = data[DATA_W+3:DATA_W];
        imm    = data[DATA_W-1:0];
        // Opcode bit 2 selects B as the ALU operand (ADD B,Im).
        alu_x  = opcode[2] ? b_q : a_q;
        {alu_c, alu_sum} = {1'b0, alu_x} + {1'b0, imm};

        pc_d  = pc_q + ADDR_W'(1);
        a_d   = a_q;
        b_d   = b_q;
        out_d = out_q;
        c_d   = 1'b0;

        case (opcode)
            OpAddA: begin
                a_d = alu_sum;
                c_d = alu_c;
            end
            OpMovAB: a_d = b_q;
            OpInA:   a_d = in_port;
            OpMovAI: a_d = imm;
            OpMovBA: b_d = a_q;
            OpAddB: begin
                b_d = alu_sum;
                c_d = alu_c;
            end
            OpInB:   b_d = in_port;
            OpMovBI: b_d = imm;
            OpOutB:  out_d = b_q;
            OpOutI:  out_d = imm;
            OpJnc: begin
                if (!c_q) pc_d = imm[ADDR_W-1:0];
            end
            OpJmp:   pc_d = imm[ADDR_W-1:0];
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            out_q <= '0;
            c_q   <= 1'b0;
        end else if (en) begin
            pc_q  <= pc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            out_q <= out_d;
            c_q   <= c_d;
        end
    end

    assign address  = pc_q;
    assign out_port = out_q;
    assign carry    = c_q;

endmodule
